// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared state encoding and defaults for the CPU memory bus controller
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      HOLD   = 2'd3
   } bus_state_t;

   localparam int          WAIT_CYCLES_DEF = 2;
   localparam logic [15:0] RAM_BASE_DEF    = 16'h2000;
   localparam logic [15:0] RAM_LAST_DEF    = 16'h3FFF;

endpackage

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - CPU to memory IO stage bus controller with fixed-latency strobed transfers
module mem_bus_ctrl
   import cpu_mem_pkg::*;
#(
   parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter logic [15:0] RAM_BASE    = RAM_BASE_DEF,
   parameter logic [15:0] RAM_LAST    = RAM_LAST_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ready,
   output logic        cpu_ack,
   output logic        cpu_err,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] mem_address,
   output logic        read_memory,
   output logic        write_memory,
   inout  wire  [7:0]  internal_data_path
);

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   bus_state_t state, state_nxt;
   logic [3:0] wait_cnt;
   logic       we_q;
   logic       in_win_q;
   logic [7:0] wdata_q;
   logic       bus_drive;
   logic       last_access;

   assign last_access = (state == ACCESS) && (wait_cnt == 4'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cpu_req) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (wait_cnt == 4'd0) state_nxt = HOLD;
         HOLD:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Out-of-window transfers run the full timeline with strobes suppressed so latency stays fixed.
   always_comb begin
      cpu_ready    = 1'b0;
      cpu_ack      = 1'b0;
      cpu_err      = 1'b0;
      read_memory  = 1'b0;
      write_memory = 1'b0;
      bus_drive    = 1'b0;
      case (state)
         IDLE: cpu_ready = 1'b1;
         ACCESS: begin
            read_memory  = in_win_q && !we_q;
            write_memory = in_win_q && we_q;
            bus_drive    = we_q;
         end
         HOLD: begin
            cpu_ack   = 1'b1;
            cpu_err   = !in_win_q;
            bus_drive = we_q;
         end
         default: ;
      endcase
   end

   assign internal_data_path = bus_drive ? wdata_q : 8'hzz;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt    <= 4'd0;
         we_q        <= 1'b0;
         in_win_q    <= 1'b0;
         wdata_q     <= 8'h00;
         mem_address <= 16'h0000;
         cpu_rdata   <= 8'h00;
      end else begin
         if (state == IDLE && cpu_req) begin
            we_q        <= cpu_we;
            wdata_q     <= cpu_wdata;
            mem_address <= cpu_addr;
            in_win_q    <= (cpu_addr >= RAM_BASE) && (cpu_addr <= RAM_LAST);
         end
         if (state == SETUP) begin
            wait_cnt <= WAIT_LOAD;
         end else if (state == ACCESS && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (last_access && !we_q) begin
            cpu_rdata <= in_win_q ? internal_data_path : 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - self-checking bench for mem_bus_ctrl
module tb_mem_bus_ctrl;
   import cpu_mem_pkg::*;

   localparam int W = WAIT_CYCLES_DEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        cpu_req = 1'b0;
   logic        req0 = 1'b0;
   logic        cpu_we = 1'b0;
   logic [15:0] cpu_addr = 16'h0000;
   logic [7:0]  cpu_wdata = 8'h00;
   logic        cpu_ready, cpu_ack, cpu_err, read_memory, write_memory;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_address;
   logic        ready_0, ack_0, err_0, read_memory_0, write_memory_0;
   logic [7:0]  rdata_0;
   logic [15:0] mem_address_0;
   logic [7:0]  mem_val = 8'h00;
   logic        tb_force = 1'b0;
   wire  [7:0]  bus, bus0;

   // memory IO stage model: drives the bus only while being read
   assign bus  = (read_memory || tb_force) ? mem_val : 8'hzz;
   assign bus0 = read_memory_0 ? mem_val : 8'hzz;

   mem_bus_ctrl dut (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
      .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
      .mem_address(mem_address), .read_memory(read_memory),
      .write_memory(write_memory), .internal_data_path(bus)
   );

   mem_bus_ctrl #(.WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .cpu_req(req0), .cpu_we(cpu_we),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ready(ready_0),
      .cpu_ack(ack_0), .cpu_err(err_0), .cpu_rdata(rdata_0),
      .mem_address(mem_address_0), .read_memory(read_memory_0),
      .write_memory(write_memory_0), .internal_data_path(bus0)
   );

   int checks = 0;
   int errors = 0;
   int ncyc = 0;
   int both_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      int         ack_cyc;
      logic       err;
      logic [7:0] rdata;
   } sb_t;

   sb_t        sb[$];
   logic       cur_err = 1'b0;
   logic [7:0] cur_rdata = 8'h00;

   always @(negedge clk) begin
      sb_t e;
      ncyc++;
      if (read_memory && write_memory) both_cnt++;
      if (read_memory_0 && write_memory_0) both_cnt++;
      if (!reset) begin
         if (cpu_ack) begin
            if (sb.size() == 0) begin
               check("unexpected_ack", cpu_ack, 32'd0);
            end else begin
               e = sb.pop_front();
               check("ack_cycle", ncyc, e.ack_cyc);
               check("ack_err", cpu_err, e.err);
               check("ack_rdata", cpu_rdata, e.rdata);
            end
         end
         if (cpu_ready && cpu_req) sb.push_back('{ncyc + 3 + W, cur_err, cur_rdata});
      end
   end

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  memval;
      logic        exp_err;
      logic [7:0]  exp_rdata;
      int          exp_wr;
      int          exp_rd;
   } vec_t;

   vec_t vecs[8];

   task automatic run_vec(input vec_t v, input bit keep_req, output int waited);
      int wr, rd, busy_ready;
      bit acked, accepted;
      @(posedge clk); #1;
      cpu_we    = v.we;
      cpu_addr  = v.addr;
      cpu_wdata = v.wdata;
      mem_val   = v.memval;
      cur_err   = v.exp_err;
      cur_rdata = v.exp_rdata;
      cpu_req   = 1'b1;
      accepted  = 1'b0;
      waited    = 0;
      for (int i = 0; i < 40 && !accepted; i++) begin
         @(negedge clk);
         waited++;
         accepted = cpu_ready;
      end
      check("accept", accepted, 32'd1);
      @(posedge clk); #1;
      cpu_req = keep_req;
      wr = 0; rd = 0; busy_ready = 0; acked = 1'b0;
      for (int i = 0; i < 40 && !acked; i++) begin
         @(negedge clk);
         if (write_memory) wr++;
         if (read_memory) rd++;
         if (cpu_ready) busy_ready++;
         if (v.we && !v.exp_err && (write_memory || cpu_ack)) check("wr_bus", bus, v.wdata);
         acked = cpu_ack;
      end
      check("ack_seen", acked, 32'd1);
      check("wr_cycles", wr, v.exp_wr);
      check("rd_cycles", rd, v.exp_rd);
      check("ready_busy", busy_ready, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int   waited, n, rd;
      bit   acked;
      vec_t v;

      vecs[0] = '{1'b1, 16'h2010, 8'hA5, 8'h00, 1'b0, 8'h00, 3, 0};
      vecs[1] = '{1'b0, 16'h3FFF, 8'hC3, 8'h3C, 1'b0, 8'h3C, 0, 3};
      vecs[2] = '{1'b0, 16'h4000, 8'h00, 8'h77, 1'b1, 8'h00, 0, 0};
      vecs[3] = '{1'b0, 16'h2000, 8'h00, 8'h5E, 1'b0, 8'h5E, 0, 3};
      vecs[4] = '{1'b0, 16'h1FFF, 8'h00, 8'h11, 1'b1, 8'h00, 0, 0};
      vecs[5] = '{1'b1, 16'h3000, 8'h69, 8'h00, 1'b0, 8'h00, 3, 0};
      vecs[6] = '{1'b0, 16'h2400, 8'hE7, 8'h81, 1'b0, 8'h81, 0, 3};
      vecs[7] = '{1'b1, 16'hFFFF, 8'h12, 8'h00, 1'b1, 8'h81, 0, 0};

      repeat (2) @(negedge clk);
      check("rst_ready", cpu_ready, 32'd1);
      check("rst_ack", cpu_ack, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("init_ready", cpu_ready, 32'd1);
      check("init_err", cpu_err, 32'd0);
      check("init_rdata", cpu_rdata, 32'h00);
      check("init_addr", mem_address, 32'h0000);
      check("init_strobes", {read_memory, write_memory}, 32'd0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0, waited);

      @(negedge clk);
      check("idle_addr_hold", mem_address, 32'hFFFF);

      // write with req held high, then a read accepted right after HOLD
      v = '{1'b1, 16'h2222, 8'h44, 8'h00, 1'b0, 8'h81, 3, 0};
      run_vec(v, 1'b1, waited);
      v = '{1'b0, 16'h2345, 8'h00, 8'h9A, 1'b0, 8'h9A, 0, 3};
      run_vec(v, 1'b0, waited);
      check("b2b_accept_wait", waited, 32'd1);

      // reset in the second ACCESS cycle of a write
      @(posedge clk); #1;
      cpu_we = 1'b1; cpu_addr = 16'h2010; cpu_wdata = 8'hA5;
      cur_err = 1'b0; cur_rdata = 8'h9A; cpu_req = 1'b1;
      @(negedge clk);
      check("mid_rst_ready_pre", cpu_ready, 32'd1);
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check("mid_rst_wr_active", write_memory, 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_wr_drop", write_memory, 32'd0);
      check("mid_rst_rd_drop", read_memory, 32'd0);
      mem_val = 8'h96; tb_force = 1'b1;
      #1;
      check("mid_rst_bus_free", bus, 32'h96);
      check("mid_rst_no_ack", cpu_ack, 32'd0);
      check("mid_rst_addr", mem_address, 32'h0000);
      check("mid_rst_rdata", cpu_rdata, 32'h00);
      sb.delete();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0; tb_force = 1'b0;
      @(negedge clk);
      check("post_rst_ready", cpu_ready, 32'd1);
      repeat (8) @(negedge clk);
      check("post_rst_idle", cpu_ready, 32'd1);

      // WAIT_CYCLES = 0 instance
      @(posedge clk); #1;
      cpu_we = 1'b0; cpu_addr = 16'h2100; mem_val = 8'hD2; req0 = 1'b1;
      @(negedge clk);
      check("w0_ready", ready_0, 32'd1);
      @(posedge clk); #1;
      req0 = 1'b0;
      n = 0; rd = 0; acked = 1'b0;
      for (int i = 0; i < 20 && !acked; i++) begin
         @(negedge clk);
         n++;
         if (read_memory_0) rd++;
         acked = ack_0;
      end
      check("w0_ack_lat", n, 32'd3);
      check("w0_rd_cycles", rd, 32'd1);
      check("w0_rdata", rdata_0, 32'hD2);
      check("w0_err", err_0, 32'd0);

      check("never_both", both_cnt, 32'd0);
      check("sb_empty", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, the number of extra strobe cycles beyond the first; legal range 0..15.
REQ-002 SHALL have parameter RAM_BASE, default 16'h2000, the first address of the RAM window.
REQ-003 SHALL have parameter RAM_LAST, default 16'h3FFF, the last address of the RAM window.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  system clock, all state updates on its rising edge.
REQ-005 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have cpu_req  input  1  CPU requests a memory transfer.
REQ-007 SHALL have cpu_we  input  1  transfer direction: 1 write, 0 read.
REQ-008 SHALL have cpu_addr  input  16  transfer address.
REQ-009 SHALL have cpu_wdata  input  8  write data.
REQ-010 SHALL have cpu_ready  output  1  controller idle; a request is accepted this cycle.
REQ-011 SHALL have cpu_ack  output  1  one-cycle transfer-complete pulse.
REQ-012 SHALL have cpu_err  output  1  qualifies cpu_ack: the address was outside the RAM window.
REQ-013 SHALL have cpu_rdata  output  8  read data, valid while cpu_ack=1 and held until the next acknowledged read.
REQ-014 SHALL have mem_address  output  16  address to the memory IO stage.
REQ-015 SHALL have read_memory  output  1  read strobe, active high.
REQ-016 SHALL have write_memory  output  1  write strobe, active high.
REQ-017 SHALL have internal_data_path  inout  8  shared data bus to the memory IO stage.

Function
REQ-018 SHALL use states IDLE, SETUP, ACCESS and HOLD.
REQ-019 SHALL assert cpu_ready only in IDLE.
REQ-020 SHALL accept a request only at a rising edge where the state is IDLE and cpu_req=1; it then latches cpu_we, cpu_addr and cpu_wdata and moves to SETUP. cpu_req is ignored in every other state.
REQ-021 SHALL, in SETUP (1 cycle), drive the latched address on mem_address with both strobes low.
REQ-022 SHALL, in ACCESS (exactly WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter), assert write_memory for a write or read_memory for a read.
REQ-023 SHALL, for an out-of-window address (below RAM_BASE or above RAM_LAST), keep both strobes low through ACCESS.
REQ-024 SHALL capture internal_data_path into cpu_rdata at the clock edge that ends the last ACCESS cycle of an in-window read.
REQ-025 SHALL, in HOLD (1 cycle), drop both strobes, keep mem_address stable, pulse cpu_ack=1, and return to IDLE.
REQ-026 SHALL set cpu_err=1 with cpu_ack for out-of-window transfers and load cpu_rdata=8'h00 for an out-of-window read.
REQ-027 SHALL give fixed latency: for a request accepted at edge k, cpu_ack is high during cycle k+3+WAIT_CYCLES (cycle k+5 at default).
REQ-028 SHALL never assert read_memory and write_memory together.
REQ-029 SHALL drive internal_data_path with the latched write data only in ACCESS and HOLD of a write; otherwise it is high impedance.
REQ-030 SHALL hold mem_address at the last latched value in IDLE; the value after reset is 16'h0000.
REQ-031 SHALL allow a new request to be accepted in the IDLE cycle immediately after HOLD, giving a back-to-back throughput of one transfer per 4+WAIT_CYCLES cycles.

Reset
REQ-032 SHALL, on reset assertion, immediately (asynchronously) go to IDLE and clear cpu_ack, cpu_err, read_memory and write_memory to 0, cpu_rdata and mem_address to 0, and the wait counter to 0, and release the data bus.
REQ-033 SHALL abandon a transfer interrupted by reset mid-operation without acknowledging it; cpu_ready=1 in the first cycle after reset deasserts.

Structure
REQ-034 SHALL place the state enumeration, the RAM_BASE/RAM_LAST defaults and the WAIT_CYCLES default in the shared package cpu_mem_pkg.
REQ-035 SHALL be a single module with no sub-module; the wait counter and the window compare are inline.

Verification
REQ-036 SHALL cover a write to 16'h2010 with data 8'hA5 at default WAIT: write_memory high for 3 cycles, bus=8'hA5 during ACCESS/HOLD, cpu_ack at k+5, cpu_err=0.
REQ-037 SHALL cover a read from 16'h3FFF with the bus modelled as 8'h3C: read_memory high for 3 cycles, cpu_rdata=8'h3C, cpu_ack at k+5, bus high impedance from this block throughout.
REQ-038 SHALL cover a read from 16'h4000 and from 16'h1FFF: no strobes, cpu_ack with cpu_err=1, cpu_rdata=8'h00.
REQ-039 SHALL cover reset asserted in the second ACCESS cycle of a write: strobes and bus released in the same cycle, no cpu_ack, cpu_ready=1 after release.
REQ-040 SHALL cover a write held with cpu_req high continuously, followed by a read: the second request is accepted in the IDLE cycle after HOLD, req is ignored while busy, and the strobes are never both high.
REQ-041 SHALL cover WAIT_CYCLES=0: a strobe of 1 cycle and cpu_ack at k+3.
